// File: rtl/io_uart_tx.sv
// IO-space peripheral: 5-bit LED latch, UART transmit data port with FIFO, and status/control.
// Queued bytes are sent on TXD as 8N1 frames, BAUD_DIV clock cycles per bit.
module io_uart_tx #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IO_mem_addr,
    output logic [31:0] IO_mem_rdata,
    input  logic [31:0] IO_mem_wdata,
    input  logic        IO_mem_wr,
    output logic [4:0]  LEDS,
    output logic        TXD
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [AW:0] FULL_COUNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sel_leds, sel_data, sel_stat;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, busy, overflow;
    logic          push_req, push, pop, clear_ovf;

    state_t        state, state_nx;
    logic [15:0]   baud_cnt, baud_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shift, shift_nx;
    logic          txd_nx;
    logic          unused_bits;

    assign sel_leds  = IO_mem_addr[22] & IO_mem_addr[2];
    assign sel_data  = IO_mem_addr[22] & IO_mem_addr[3];
    assign sel_stat  = IO_mem_addr[22] & IO_mem_addr[4];
    assign unused_bits = ^{IO_mem_addr[31:23], IO_mem_addr[21:5], IO_mem_addr[1:0],
                           IO_mem_wdata[31:8]};

    assign full      = (count == FULL_COUNT);
    assign busy      = (state != IDLE) | (count != '0);
    assign push_req  = IO_mem_wr & sel_data;
    // A full FIFO still takes the byte when the transmitter frees a slot this cycle.
    assign push      = push_req & (~full | pop);
    assign clear_ovf = IO_mem_wr & sel_stat & IO_mem_wdata[2];

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        shift_nx = shift;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    shift_nx = fifo_mem[rd_ptr];
                    state_nx = START;
                    baud_nx  = BAUD_RELOAD;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    state_nx = DATA;
                    bit_nx   = '0;
                    baud_nx  = BAUD_RELOAD;
                end else begin
                    baud_nx = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_nx = BAUD_RELOAD;
                    if (bit_idx == 3'd7) state_nx = STOP;
                    else                 bit_nx   = bit_idx + 3'd1;
                end else begin
                    baud_nx = baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (count != '0) begin
                        pop      = 1'b1;
                        shift_nx = fifo_mem[rd_ptr];
                        state_nx = START;
                        baud_nx  = BAUD_RELOAD;
                    end else begin
                        state_nx = IDLE;
                        baud_nx  = '0;
                    end
                end else begin
                    baud_nx = baud_cnt - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // TXD is registered from the next-state values so it changes only on clock edges.
    always_comb begin
        txd_nx = 1'b1;
        case (state_nx)
            START:   txd_nx = 1'b0;
            DATA:    txd_nx = shift_nx[bit_nx];
            default: txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TXD      <= 1'b1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            LEDS     <= '0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_idx  <= bit_nx;
            shift    <= shift_nx;
            TXD      <= txd_nx;
            if (IO_mem_wr & sel_leds) LEDS <= IO_mem_wdata[4:0];
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push & ~pop)      count <= count + CNT_ONE;
            else if (pop & ~push) count <= count - CNT_ONE;
            overflow <= (push_req & ~push) | (overflow & ~clear_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= IO_mem_wdata[7:0];
    end

    always_comb begin
        IO_mem_rdata = '0;
        if (sel_leds) IO_mem_rdata |= {27'b0, LEDS};
        if (sel_stat) IO_mem_rdata |= {19'b0, 5'(count), 5'b0, overflow, full, busy};
    end
endmodule

// File: tb/tb_io_uart_tx.sv
// Scoreboard bench for io_uart_tx: a cycle-level timing model predicts accepted bytes and frame
// start cycles; an independent TXD monitor decodes frames and checks them against the queue.
module tb_io_uart_tx;
    localparam int B     = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] addr, rdata, wdata;
    logic        wr;
    logic [4:0]  leds;
    logic        txd;

    io_uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .IO_mem_addr(addr), .IO_mem_rdata(rdata),
        .IO_mem_wdata(wdata), .IO_mem_wr(wr), .LEDS(leds), .TXD(txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [7:0] data; int start; } frame_t;
    frame_t     exp_q[$];
    int         push_c[$];
    int         pop_c[$];
    logic [4:0] leds_m;
    logic       ovf_m;

    logic [31:0] waddrs [5] = '{32'h0040_0004, 32'h0040_000C, 32'h0040_0018,
                                32'h0040_0014, 32'h0000_001C};
    logic [31:0] raddrs [6] = '{32'h0040_0004, 32'h0040_0008, 32'h0040_0010,
                                32'h0040_001C, 32'h0040_000C, 32'h0000_0014};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Bytes still queued in cycle c: pushed earlier, popped in c or later.
    function automatic int count_at(input int c);
        int n = 0;
        foreach (push_c[i]) if (push_c[i] < c && pop_c[i] >= c) n++;
        return n;
    endfunction

    // Busy from the cycle after a push until the last stop-bit cycle of its frame.
    function automatic bit busy_at(input int c);
        foreach (push_c[i]) if (push_c[i] < c && c <= pop_c[i] + 10*B) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] status_at(input int c);
        int n = count_at(c);
        return {19'b0, 5'(n), 5'b0, ovf_m, (n == DEPTH), busy_at(c)};
    endfunction

    task automatic model_push(input int n, input logic [7:0] d);
        int later = 0;
        int p;
        foreach (pop_c[i]) if (pop_c[i] > n) later++;
        if (later < DEPTH) begin
            p = n + 1;
            if (pop_c.size() > 0 && pop_c[$] + 10*B > p) p = pop_c[$] + 10*B;
            push_c.push_back(n);
            pop_c.push_back(p);
            exp_q.push_back('{data: d, start: p + 1});
        end else begin
            ovf_m = 1'b1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int n = cyc;
        if (a[22] && a[4] && d[2]) ovf_m = 1'b0;
        if (a[22] && a[3]) model_push(n, d[7:0]);
        if (a[22] && a[2]) leds_m = d[4:0];
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input string nm);
        logic [31:0] want = '0;
        int n = cyc;
        if (a[22]) begin
            if (a[2]) want |= {27'b0, leds_m};
            if (a[4]) want |= status_at(n);
        end
        addr = a; wr = 1'b0;
        @(negedge clk);
        check(nm, rdata, want);
        check("leds", {27'b0, leds}, {27'b0, leds_m});
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        addr = '0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while ((exp_q.size() != 0 || busy_at(cyc)) && k < limit) begin
            do_read(32'h0040_0010, "status_busy");
            k++;
        end
        if (k >= limit) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d frames pending want 0", exp_q.size());
        end
        do_read(32'h0040_0010, "status_idle");
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        exp_q.delete(); push_c.delete(); pop_c.delete();
        ovf_m = 1'b0; leds_m = '0;
        @(posedge clk);
        @(negedge clk);
        check("txd_after_reset", {31'b0, txd}, 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // TXD monitor: decodes every frame cycle by cycle and compares against the expected queue.
    initial begin : monitor
        int         s, errs, idx, bitv;
        bit         aborted;
        frame_t     e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && txd === 1'b0) begin
                s = cyc; errs = 0; aborted = 1'b0; got = '0;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame: got start at cycle %0d want no frame", s);
                    for (int k = 1; k < 10*B; k++) begin
                        @(negedge clk);
                        if (resetn !== 1'b1) break;
                    end
                end else begin
                    e = exp_q.pop_front();
                    check("frame_start", s, e.start);
                    for (int k = 0; k < 10*B; k++) begin
                        if (k > 0) @(negedge clk);
                        if (resetn !== 1'b1) begin aborted = 1'b1; break; end
                        idx  = k / B;
                        bitv = (idx == 0) ? 0 : (idx == 9) ? 1 : int'(e.data[idx-1]);
                        if (txd !== 1'(bitv)) errs++;
                        if (idx >= 1 && idx <= 8 && (k % B) == B/2) got[idx-1] = txd;
                    end
                    if (!aborted) begin
                        check("frame_data", {24'b0, got}, {24'b0, e.data});
                        check("frame_shape_errs", errs, 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        int s;
        int r;
        addr = '0; wdata = '0; wr = 1'b0; resetn = 1'b0;
        leds_m = '0; ovf_m = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("txd_reset", {31'b0, txd}, 32'd1);
        check("leds_reset", {27'b0, leds}, 32'd0);
        check("rdata_nonio_reset", rdata, 32'd0);
        @(posedge clk); #1;
        do_read(32'h0040_0010, "status_reset");

        do_write(32'h0040_0004, 32'h0000_001F);
        do_read(32'h0040_0004, "leds_read");
        do_write(32'h0040_0004, 32'hFFFF_FFE0);
        do_read(32'h0040_0004, "leds_clear");
        do_write(32'h0000_0004, 32'h0000_001F);
        do_read(32'h0000_0004, "non_io_read");

        do_write(32'h0040_0008, 32'h0000_00A5);
        wait_drain(200);

        do_write(32'h0040_0008, 32'h0000_0055);
        do_write(32'h0040_0008, 32'h0000_000F);
        wait_drain(300);

        for (int i = 0; i < 6; i++) do_write(32'h0040_0008, 32'(8'h30 + i));
        do_read(32'h0040_0010, "status_overflow");
        do_write(32'h0040_0010, 32'h0000_0004);
        do_read(32'h0040_0010, "status_ovf_clear");
        wait_drain(400);

        repeat (400) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      do_write(32'h0040_0008, $urandom);
            else if (r < 50) do_write(waddrs[$urandom_range(0, 4)], $urandom);
            else if (r < 85) do_read(raddrs[$urandom_range(0, 5)], "rand_read");
            else             idle_cycle();
        end
        wait_drain(1000);
        do_write(32'h0040_0010, 32'h0000_0004);
        do_read(32'h0040_0010, "status_final_clear");

        do_write(32'h0040_0008, 32'h0000_00C3);
        s = pop_c[$] + 1;
        do_write(32'h0040_0008, 32'h0000_003C);
        do_write(32'h0040_0008, 32'h0000_0099);
        while (cyc < s + 4*B + 1) begin
            @(posedge clk); #1;
        end
        apply_reset();
        do_read(32'h0040_0010, "status_after_reset");
        repeat (100) idle_cycle();
        check("frames_outstanding", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped IO peripheral on the processor's IO bus, downstream of the core's execute stage. Decodes IO-space accesses (address bit 22 set) and serves three one-hot-selected registers: a 5-bit LED latch, a UART transmit data port backed by a small FIFO, and a UART status/control register. The block serialises queued bytes on TXD as 8N1 frames at a fixed baud divisor, so software can issue stores without polling for each byte.

## Interface

Parameters:
- BAUD_DIV, 434: clock cycles per UART bit (434 gives 115200 baud at 50 MHz); legal range 2..65535.
- FIFO_DEPTH, 8: transmit FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- IO_mem_addr  in  32  byte address from the core; bit 22 marks IO space.
- IO_mem_rdata  out  32  read data, combinational from IO_mem_addr and current register state.
- IO_mem_wdata  in  32  write data.
- IO_mem_wr  in  1  one-cycle write strobe.
- LEDS  out  5  LED latch.
- TXD  out  1  UART serial output; idle high.

## Operation

- Select: sel_leds = addr[22]&addr[2]; sel_data = addr[22]&addr[3]; sel_stat = addr[22]&addr[4]. Several bits may be set at once: each selected register is written, and reads return the OR of all selected registers. addr[22]=0 gives rdata 0 and no writes.
- LEDS: on wr&sel_leds, LEDS <= wdata[4:0]. Read returns {27'b0, LEDS}.
- UART_DATA: on wr&sel_data, wdata[7:0] is pushed. The push is accepted if the FIFO is not full, or if the TX FSM pops in the same cycle. Otherwise the byte is dropped and overflow is set. Read returns 0.
- UART_STATUS read: bit0 busy = (state!=IDLE)|(count!=0); bit1 full = (count==FIFO_DEPTH); bit2 overflow (sticky); bits[12:8] count; all other bits 0. On wr&sel_stat with wdata[2]=1, overflow is cleared. If an overflow occurs in the same cycle as the clear, set wins.
- FIFO: circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth. count has log2(FIFO_DEPTH)+1 bits. A simultaneous push and pop leaves count unchanged.
- TX FSM states: IDLE, START, DATA, STOP. A baud counter reloads to BAUD_DIV-1 on each bit entry and decrements to 0. A 3-bit index selects the data bit.
  - IDLE: TXD=1. If count!=0: pop into the shift register and go to START.
  - START: TXD=0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: TXD = shift[index], LSB first, BAUD_DIV cycles per bit. After bit 7 go to STOP.
  - STOP: TXD=1 for BAUD_DIV cycles. At the end, if count!=0, pop and go directly to START (no idle gap); else go to IDLE.
- TXD is driven from a register (glitch-free).

## Timing

- Reset values: LEDS=0, TXD=1, FIFO empty (pointers 0, count 0), overflow=0, state IDLE, baud counter 0. IO_mem_rdata follows the register state, so a status read after reset returns 0.
- Reset asserted mid-frame: the frame is truncated, TXD=1 from the next cycle, and FIFO contents are discarded.
- Register write: the strobe in cycle N is visible on rdata and outputs from cycle N+1.
- UART latency: a push in cycle N to an empty FIFO with IDLE gives a pop in N+1 and TXD=0 from N+2.
- Frame length: exactly 10*BAUD_DIV cycles. Back-to-back frames are contiguous.
- busy drops to 0 in the first IDLE cycle after the last STOP bit.

## Test plan

- Reset then read: reset, read addr 0x400010 -> rdata 0; TXD=1; LEDS=0.
- LED write: write 0x1F to 0x400004 -> LEDS=5'h1F next cycle; read 0x400004 -> 0x1F; write 0xFFFFFFE0 -> LEDS=0.
- Single byte: BAUD_DIV=4, write 0xA5 to 0x400008 -> TXD low 2 cycles later. The frame decodes as 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. busy=1 throughout, then 0.
- Back-to-back: push 0x55 and 0x0F consecutively -> two frames with no idle cycle between them (80 cycles total at BAUD_DIV=4).
- Overflow: FIFO_DEPTH=4, BAUD_DIV=16. Push 6 bytes in 6 cycles -> 1 popped plus 4 queued, 6th dropped; status bit1=1, bit2=1. Write 0x4 to 0x400010 -> bit2=0. Exactly 5 frames are transmitted.
- Reset mid-frame: assert resetn=0 during DATA bit 3 -> TXD=1 the next cycle, count=0, no further frames.
